// File: rtl/switch_alloc_pkg.sv
// Shared types and helpers for the router switch allocator.
package switch_alloc_pkg;

    // Per-output reservation state.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } alloc_state_t;

    // Router port directions as used by routing computation.
    localparam int unsigned NORTH = 0;
    localparam int unsigned SOUTH = 1;
    localparam int unsigned WEST  = 2;
    localparam int unsigned EAST  = 3;
    localparam int unsigned LOCAL = 4;

    // Round-robin successor of idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational N-way round-robin arbiter: first requester at or above ptr_i
// (wrapping) wins; grant is one-hot plus its encoded index.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [IdxW:0]   sum;
    logic [IdxW-1:0] cand;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int unsigned off = 0; off < N; off++) begin
            sum = {1'b0, ptr_i} + (IdxW + 1)'(off);
            if (sum >= (IdxW + 1)'(N)) begin
                sum = sum - (IdxW + 1)'(N);
            end
            cand = sum[IdxW-1:0];
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator for the mux-based crossbar: per-output round-robin
// arbitration with wormhole hold until the owner's tail flit transfers.
// Optional idle watchdog enabled by defining SWITCH_ALLOC_WATCHDOG_EN.
module switch_allocator
    import switch_alloc_pkg::*;
#(
    parameter int unsigned INPUTS          = 4,
    parameter int unsigned OUTPUTS         = 4,
    parameter int unsigned REQUEST_WIDTH   = 32,
    parameter int unsigned WATCHDOG_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [INPUTS-1:0]                  route_req,
    input  logic [INPUTS*REQUEST_WIDTH-1:0]    route_dest,
    output logic [INPUTS-1:0]                  route_gnt,
    input  logic [INPUTS-1:0]                  tail_done,
    input  logic [OUTPUTS-1:0]                 out_fire,
    output logic [OUTPUTS*REQUEST_WIDTH-1:0]   routeSelect,
    output logic [OUTPUTS-1:0]                 outputBusy,
    output logic [INPUTS-1:0]                  PortReserved,
    output logic [INPUTS-1:0]                  dest_err,
    output logic [OUTPUTS-1:0]                 wd_expired
);

    localparam int unsigned PtrW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    alloc_state_t             state_q [OUTPUTS];
    alloc_state_t             state_d [OUTPUTS];
    logic [PtrW-1:0]          ptr_q   [OUTPUTS];
    logic [PtrW-1:0]          ptr_d   [OUTPUTS];
    logic [REQUEST_WIDTH-1:0] sel_q   [OUTPUTS];
    logic [REQUEST_WIDTH-1:0] sel_d   [OUTPUTS];
    logic [INPUTS-1:0]        reserved_q, reserved_d;
    logic [INPUTS-1:0]        gnt_q, gnt_d;
    logic [INPUTS-1:0]        dest_err_q, dest_err_d;

    logic [REQUEST_WIDTH-1:0] dest     [INPUTS];
    logic [INPUTS-1:0]        elig     [OUTPUTS];
    logic [INPUTS-1:0]        arb_gnt  [OUTPUTS];
    logic [PtrW-1:0]          arb_idx  [OUTPUTS];
    logic [OUTPUTS-1:0]       arb_valid;
    logic [OUTPUTS-1:0]       tail_rel;
    logic [OUTPUTS-1:0]       wd_rel;
    logic [OUTPUTS-1:0]       rel;
    logic [INPUTS-1:0]        in_rel;
    logic [INPUTS-1:0]        in_gnt;

    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_dest
        assign dest[gi] = route_dest[gi*REQUEST_WIDTH +: REQUEST_WIDTH];
    end

    // Eligibility uses registered busy/reserved so a release is re-arbitrated
    // only in the following cycle.
    always_comb begin
        for (int o = 0; o < OUTPUTS; o++) begin
            elig[o] = '0;
            for (int i = 0; i < INPUTS; i++) begin
                elig[o][i] = route_req[i] && (dest[i] == REQUEST_WIDTH'(o)) &&
                             !reserved_q[i] && (state_q[o] == IDLE);
            end
        end
    end

    for (genvar go = 0; go < OUTPUTS; go++) begin : g_arb
        rr_arbiter #(
            .N    (INPUTS),
            .IdxW (PtrW)
        ) u_arb (
            .req_i   (elig[go]),
            .ptr_i   (ptr_q[go]),
            .gnt_o   (arb_gnt[go]),
            .idx_o   (arb_idx[go]),
            .valid_o (arb_valid[go])
        );
        assign routeSelect[go*REQUEST_WIDTH +: REQUEST_WIDTH] = sel_q[go];
    end

    // Tail release: only the owning input's tail_done frees a busy output.
    always_comb begin
        for (int o = 0; o < OUTPUTS; o++) begin
            tail_rel[o] = 1'b0;
            if (state_q[o] == BUSY) begin
                for (int i = 0; i < INPUTS; i++) begin
                    if ((sel_q[o] == REQUEST_WIDTH'(i)) && tail_done[i]) begin
                        tail_rel[o] = 1'b1;
                    end
                end
            end
        end
    end

    assign rel = tail_rel | wd_rel;

    // Map output releases and grants back onto the inputs involved.
    always_comb begin
        in_rel = '0;
        in_gnt = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            in_gnt = in_gnt | arb_gnt[o];
            for (int i = 0; i < INPUTS; i++) begin
                if (rel[o] && (sel_q[o] == REQUEST_WIDTH'(i))) begin
                    in_rel[i] = 1'b1;
                end
            end
        end
    end

    // Per-output FSM, pointer and route-select next state.
    always_comb begin
        for (int o = 0; o < OUTPUTS; o++) begin
            state_d[o] = state_q[o];
            ptr_d[o]   = ptr_q[o];
            sel_d[o]   = sel_q[o];
            unique case (state_q[o])
                IDLE: begin
                    if (arb_valid[o]) begin
                        state_d[o] = BUSY;
                        ptr_d[o]   = PtrW'(rr_next(32'(arb_idx[o]), INPUTS));
                        sel_d[o]   = REQUEST_WIDTH'(arb_idx[o]);
                    end
                end
                BUSY: begin
                    if (rel[o]) begin
                        state_d[o] = IDLE;
                    end
                end
            endcase
        end
    end

    // Input-side reservation, grant pulse and sticky destination error.
    always_comb begin
        reserved_d = (reserved_q & ~in_rel) | in_gnt;
        gnt_d      = in_gnt;
        dest_err_d = dest_err_q;
        for (int i = 0; i < INPUTS; i++) begin
            if (route_req[i] && (dest[i] >= REQUEST_WIDTH'(OUTPUTS))) begin
                dest_err_d[i] = 1'b1;
            end
        end
    end

    // Allocator state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < OUTPUTS; o++) begin
                state_q[o] <= IDLE;
                ptr_q[o]   <= '0;
                sel_q[o]   <= '0;
            end
            reserved_q <= '0;
            gnt_q      <= '0;
            dest_err_q <= '0;
        end else begin
            for (int o = 0; o < OUTPUTS; o++) begin
                state_q[o] <= state_d[o];
                ptr_q[o]   <= ptr_d[o];
                sel_q[o]   <= sel_d[o];
            end
            reserved_q <= reserved_d;
            gnt_q      <= gnt_d;
            dest_err_q <= dest_err_d;
        end
    end

    always_comb begin
        for (int o = 0; o < OUTPUTS; o++) begin
            outputBusy[o] = (state_q[o] == BUSY);
        end
    end

    assign route_gnt    = gnt_q;
    assign PortReserved = reserved_q;
    assign dest_err     = dest_err_q;

`ifdef SWITCH_ALLOC_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(WATCHDOG_CYCLES + 1);

    logic [WdW-1:0]     wd_cnt_q [OUTPUTS];
    logic [WdW-1:0]     wd_cnt_d [OUTPUTS];
    logic [OUTPUTS-1:0] wd_exp_q, wd_exp_d;

    // Count busy cycles without a transfer; expiry forces a release.
    always_comb begin
        wd_exp_d = wd_exp_q;
        for (int o = 0; o < OUTPUTS; o++) begin
            wd_rel[o] = (state_q[o] == BUSY) && (wd_cnt_q[o] >= WdW'(WATCHDOG_CYCLES));
            if ((state_q[o] != BUSY) || out_fire[o] || tail_rel[o] || wd_rel[o]) begin
                wd_cnt_d[o] = '0;
            end else begin
                wd_cnt_d[o] = wd_cnt_q[o] + 1'b1;
            end
            if (wd_rel[o]) begin
                wd_exp_d[o] = 1'b1;
            end
        end
    end

    // Watchdog counters and sticky expiry flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < OUTPUTS; o++) begin
                wd_cnt_q[o] <= '0;
            end
            wd_exp_q <= '0;
        end else begin
            for (int o = 0; o < OUTPUTS; o++) begin
                wd_cnt_q[o] <= wd_cnt_d[o];
            end
            wd_exp_q <= wd_exp_d;
        end
    end

    assign wd_expired = wd_exp_q;
`else
    logic unused_wd;

    assign wd_rel     = '0;
    assign wd_expired = '0;
    assign unused_wd  = ^{out_fire, WATCHDOG_CYCLES};
`endif

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Switch control logic for the mux-based crossbar in each router.
- Takes per-input route requests from routing computation and arbitrates each output port round-robin among its requesters.
- Holds each granted input→output path (wormhole) until that input's tail flit transfers.
- Drives the crossbar's routeSelect, outputBusy and PortReserved controls from registers.

Parameters:
- INPUTS, 4, number of router input ports.
- OUTPUTS, 4, number of router output ports.
- REQUEST_WIDTH, 32, width of the encoded input index per output (routeSelect) and of a requested destination.
- WATCHDOG_CYCLES, 1024, idle-cycle limit for forced release; used only with the optional feature.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- route_req  input  INPUTS  input i has a head flit waiting and requests route_dest[i].
- route_dest  input  INPUTS×REQUEST_WIDTH  requested output index per input.
- route_gnt  output  INPUTS  one-cycle pulse: input i granted its requested output.
- tail_done  input  INPUTS  tail flit of input i transferred (valid_in&ready_in&tail) this cycle.
- out_fire  input  OUTPUTS  flit transferred on output o (valid_out&ready_out) this cycle.
- routeSelect  output  OUTPUTS×REQUEST_WIDTH  registered input index feeding output o.
- outputBusy  output  OUTPUTS  output o is reserved.
- PortReserved  output  INPUTS  input i owns an output.
- dest_err  output  INPUTS  sticky: input i requested route_dest ≥ OUTPUTS.
- wd_expired  output  OUTPUTS  sticky: watchdog force-released output o (held 0 without the optional feature).

Behaviour:
- Reset: all outputs are 0, all state is IDLE, and every round-robin pointer is 0. Reset is asynchronous and may occur mid-packet; it drops all reservations immediately.
- Per-output FSM:
  - IDLE→BUSY on grant.
  - BUSY→IDLE on tail_done of the owning input (routeSelect[o] identifies the owner).
  - No other transitions, except the watchdog (optional feature).
- Eligibility: input i is eligible for output o when all of the following hold:
  - route_req[i] = 1;
  - route_dest[i] = o;
  - PortReserved[i] = 0;
  - outputBusy[o] = 0 (registered value).
- Requests from an input that is already reserved are ignored.
- Arbitration (per IDLE output, every cycle):
  - Round-robin starting at ptr[o].
  - The first eligible input from ptr[o] upward (mod INPUTS) wins.
  - On a grant, ptr[o] ← winner+1 (mod INPUTS).
  - ptr[o] is unchanged when there is no grant.
- Grant latency: grant decided in cycle N. In cycle N+1, route_gnt[i]=1 for exactly one cycle, and outputBusy[o], PortReserved[i] and routeSelect[o]=i are all valid.
- An input holds at most one output. Each input requests exactly one output, so two outputs can never grant the same input.
- Release:
  - tail_done[i] in cycle N → outputBusy[o] and PortReserved[i] drop at N+1.
  - routeSelect[o] keeps its last value (don't-care while not busy).
  - Output o is re-arbitrated at N+1, so the next grant is visible at N+2. This one-cycle bubble is intentional.
- Simultaneous events:
  - tail_done and a new request for the same output in the same cycle: the request waits for the release; it is not granted that cycle.
  - tail_done on an input that is not reserved is ignored.
- Invalid destination: route_dest[i] ≥ OUTPUTS while route_req[i]=1 sets dest_err[i] at N+1. No grant is issued. The bit clears only on reset.
- route_req is level; the requester holds it until route_gnt. Deasserting route_req before grant withdraws the request with no side effect.

Optional Feature:
- Macro SWITCH_ALLOC_WATCHDOG_EN.
- Defined:
  - Per-output counter, width $clog2(WATCHDOG_CYCLES+1).
  - Counts consecutive BUSY cycles with out_fire[o]=0; clears on out_fire, on release, and when IDLE.
  - On reaching WATCHDOG_CYCLES: output o and its owner input are force-released next cycle, and wd_expired[o] is set (sticky until reset).
- Undefined: no counters; wd_expired is tied 0; out_fire is unused.

Decomposition:
- Package switch_alloc_pkg:
  - alloc_state_t enum {IDLE, BUSY};
  - direction constants (NORTH=0, SOUTH=1, WEST=2, EAST=3, LOCAL=4);
  - a function returning the next round-robin index.
- Sub-module rr_arbiter:
  - N-requester, one-hot grant, pointer input;
  - instantiated once per output.

Test Plan:
- Single path: route_req[2]=1, dest=1 → route_gnt[2] pulse one cycle later; outputBusy[1]=1, PortReserved[2]=1, routeSelect[1]=2. tail_done[2] → both clear next cycle.
- Contention: inputs 0, 1, 3 request output 0 continuously, each releasing after 3 cycles → grants in order 0, 1, 3, 0; ptr wraps correctly.
- Release/request same cycle: input 1 owns output 2; input 0 requests output 2 in the tail_done[1] cycle → input 0 granted exactly 2 cycles later, never overlapping.
- Bad dest: route_dest[3]=7 with OUTPUTS=4 → dest_err[3]=1 next cycle, no route_gnt, other ports unaffected.
- Reset mid-packet: rst_n low while 3 paths are reserved → all outputs 0 immediately (asynchronous); ptrs return to 0.
- Watchdog (macro defined, WATCHDOG_CYCLES=8): output 3 busy, no out_fire for 8 cycles → forced release, wd_expired[3]=1.
